// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb : register file with per-register pending (scoreboard) bits.
//
// Sits between decode (reads, pending sets) and writeback (writes, pending
// clears). Two combinational read ports, one synchronous write port,
// optional hardwired-zero register 0 and optional write-to-read bypass.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset (clears data and pending)
//   we        in   write enable
//   waddr     in   write address
//   wdata     in   write data
//   raddr1    in   read port 1 address
//   rdata1    out  read port 1 data (combinational)
//   busy1     out  pending bit of raddr1 (combinational)
//   raddr2    in   read port 2 address
//   rdata2    out  read port 2 data (combinational)
//   busy2     out  pending bit of raddr2 (combinational)
//   set_pend  in   mark set_addr pending (instruction issued)
//   set_addr  in   register to mark pending
//   any_pend  out  OR of all pending bits
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             busy1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic             busy2,
    input  logic             set_pend,
    input  logic [AW-1:0]    set_addr,
    output logic             any_pend
);

    localparam logic ZERO_EN   = (ZERO_REG != 32'd0);
    localparam logic BYPASS_EN = (BYPASS != 32'd0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;

    // An access to register 0 is void when it is hardwired to zero.
    logic w_wr_ok;
    logic w_set_ok;
    assign w_wr_ok  = we && !(ZERO_EN && (waddr == {AW{1'b0}}));
    assign w_set_ok = set_pend && !(ZERO_EN && (set_addr == {AW{1'b0}}));

    // Register storage: written only by an accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Pending bits: a write clears, an issue sets; the set is applied last so
    // a same-edge set on the written register wins (newer producer).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= {DEPTH{1'b0}};
        end else begin
            if (w_wr_ok) begin
                r_pend[waddr] <= 1'b0;
            end
            if (w_set_ok) begin
                r_pend[set_addr] <= 1'b1;
            end
        end
    end

    // Read port 1: storage lookup, bypass override, forced to zero in reset.
    always_comb begin
        rdata1 = r_mem[raddr1];
        busy1  = r_pend[raddr1];
        if (!reset_n) begin
            rdata1 = {WIDTH{1'b0}};
            busy1  = 1'b0;
        end else if (BYPASS_EN && w_wr_ok && (waddr == raddr1)) begin
            rdata1 = wdata;
            busy1  = 1'b0;
        end else begin
            rdata1 = r_mem[raddr1];
            busy1  = r_pend[raddr1];
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        rdata2 = r_mem[raddr2];
        busy2  = r_pend[raddr2];
        if (!reset_n) begin
            rdata2 = {WIDTH{1'b0}};
            busy2  = 1'b0;
        end else if (BYPASS_EN && w_wr_ok && (waddr == raddr2)) begin
            rdata2 = wdata;
            busy2  = 1'b0;
        end else begin
            rdata2 = r_mem[raddr2];
            busy2  = r_pend[raddr2];
        end
    end

    // Drain indication, forced low while reset is held.
    assign any_pend = reset_n & (|r_pend);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        set_pend;
    logic [4:0]  set_addr;

    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic        busy1, busy2, any_pend, nb_busy1, nb_busy2, nb_any_pend;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
        .raddr2(raddr2), .rdata2(rdata2), .busy2(busy2),
        .set_pend(set_pend), .set_addr(set_addr), .any_pend(any_pend)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(nb_rdata1), .busy1(nb_busy1),
        .raddr2(raddr2), .rdata2(nb_rdata2), .busy2(nb_busy2),
        .set_pend(set_pend), .set_addr(set_addr), .any_pend(nb_any_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        sp;
        logic [4:0]  sa;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic        eb1;
        logic [31:0] e2;
        logic        eb2;
        logic        eany;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic sp, input logic [4:0] sa,
                         input logic [4:0] r1, input logic [4:0] r2);
        we = w; waddr = wa; wdata = wd; set_pend = sp; set_addr = sa;
        raddr1 = r1; raddr2 = r2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, raddr1, raddr2);
    endtask

    initial begin
        // Main directed table (BYPASS=1 instance), checked before each edge.
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd31, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd6,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5,  32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7,  32'h0,        1'b0, 32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 5'd9, 32'h00000042, 1'b0, 5'd0, 5'd9, 5'd9,  32'h00000042, 1'b0, 32'h00000042, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9,  32'h00000042, 1'b0, 32'h00000042, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd9, 32'h00000077, 1'b1, 5'd9, 5'd9, 5'd7,  32'h00000077, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9,  32'h00000077, 1'b1, 32'h00000077, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 5'd9, 32'h00000088, 1'b0, 5'd0, 5'd3, 5'd4,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0,  32'h00000088, 1'b0, 32'h0,        1'b0, 1'b0};

        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state on every address, both ports.
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("rst_rdata1", rdata1, 32'h0);
            check("rst_rdata2", rdata2, 32'h0);
            check("rst_busy", {30'h0, busy1, busy2}, 32'h0);
        end
        check("rst_any_pend", {31'h0, any_pend}, 32'h0);

        // Table-driven vectors.
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].sp, vecs[v].sa,
                  vecs[v].r1, vecs[v].r2);
            #1;
            check($sformatf("vec%0d_rdata1", v), rdata1, vecs[v].e1);
            check($sformatf("vec%0d_busy1", v), {31'h0, busy1}, {31'h0, vecs[v].eb1});
            check($sformatf("vec%0d_rdata2", v), rdata2, vecs[v].e2);
            check($sformatf("vec%0d_busy2", v), {31'h0, busy2}, {31'h0, vecs[v].eb2});
            check($sformatf("vec%0d_any", v), {31'h0, any_pend}, {31'h0, vecs[v].eany});
        end

        // No-bypass instance: old data and live pending bit until the edge.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd13, 5'd13);
        @(negedge clk);
        drive(1'b1, 5'd13, 32'h00001111, 1'b0, 5'd0, 5'd13, 5'd13);
        #1;
        check("nb_old_rdata1", nb_rdata1, 32'h0);
        check("nb_busy1_pre", {31'h0, nb_busy1}, 32'h1);
        check("byp_rdata1", rdata1, 32'h00001111);
        check("byp_busy1", {31'h0, busy1}, 32'h0);
        @(negedge clk);
        idle();
        #1;
        check("nb_new_rdata1", nb_rdata1, 32'h00001111);
        check("nb_busy1_post", {31'h0, nb_busy1}, 32'h0);
        check("nb_any_post", {31'h0, nb_any_pend}, 32'h0);

        // Reset mid-operation: 3 and 4 written and left pending.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h00000033, 1'b1, 5'd3, 5'd3, 5'd4);
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h00000044, 1'b1, 5'd4, 5'd3, 5'd4);
        @(negedge clk);
        idle();
        #1;
        check("pre_rst_rdata1", rdata1, 32'h00000033);
        check("pre_rst_rdata2", rdata2, 32'h00000044);
        check("pre_rst_busy", {30'h0, busy1, busy2}, 32'h3);
        check("pre_rst_any", {31'h0, any_pend}, 32'h1);
        #1;
        reset_n = 1'b0;
        drive(1'b1, 5'd3, 32'h00000099, 1'b1, 5'd3, 5'd3, 5'd4);
        #1;
        check("in_rst_rdata1", rdata1, 32'h0);
        check("in_rst_rdata2", rdata2, 32'h0);
        check("in_rst_busy", {30'h0, busy1, busy2}, 32'h0);
        check("in_rst_any", {31'h0, any_pend}, 32'h0);
        check("in_rst_nb_rdata1", nb_rdata1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        #1;
        check("post_rst_rdata1", rdata1, 32'h0);
        check("post_rst_rdata2", rdata2, 32'h0);
        check("post_rst_busy", {30'h0, busy1, busy2}, 32'h0);
        check("post_rst_any", {31'h0, any_pend}, 32'h0);
        @(negedge clk);
        #1;
        check("post_rst2_rdata1", rdata1, 32'h0);
        check("post_rst2_any", {31'h0, any_pend}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
